// File: rtl/synth_sysex_pkg.sv
// synth_sysex_pkg
//   Shared SysEx framing constants, the dump/load FSM state encoding and the
//   parameter-bus region defaults. Used by the patch dump sequencer and by the
//   future patch-load receiver.
//   Contents: SOX/EOX/CMD_DUMP bytes, OSC_STRIDE_DEF/COM_LEN_DEF,
//             sysex_state_e, checksum_byte() helper.
package synth_sysex_pkg;

  localparam logic [7:0] SOX      = 8'hF0;
  localparam logic [7:0] EOX      = 8'hF7;
  localparam logic [7:0] CMD_DUMP = 8'h10;

  localparam int OSC_STRIDE_DEF = 16;
  localparam int COM_LEN_DEF    = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_SETUP   = 3'd2,
    ST_STROBE  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_SEND    = 3'd5,
    ST_SUM     = 3'd6,
    ST_EOX     = 3'd7
  } sysex_state_e;

  // Two's-complement style 7-bit checksum: data bytes plus this byte sum to 0 mod 128.
  function automatic logic [7:0] checksum_byte(input logic [6:0] sum);
    logic [7:0] diff;
    diff = 8'h80 - {1'b0, sum};
    return diff & 8'h7F;
  endfunction

endpackage

// File: rtl/patch_dump_sequencer_if.sv
// patch_dump_sequencer_if
//   Synth parameter bus (read side) plus the byte-stream handshake toward the
//   MIDI transmitter.
//   master: the dump sequencer (drives address/selects/strobe and tx byte)
//   slave : register-file slaves and transmitter (drive data and tx_ready)
interface patch_dump_sequencer_if;
  import synth_sysex_pkg::*;

  logic [6:0] adr;
  logic       osc_sel;
  logic       com_sel;
  logic       read;
  logic       sysex_data_patch_send;
  logic [7:0] data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output adr, osc_sel, com_sel, read, sysex_data_patch_send, tx_data, tx_valid,
    input  data, tx_ready
  );

  modport slave (
    input  adr, osc_sel, com_sel, read, sysex_data_patch_send, tx_data, tx_valid,
    output data, tx_ready
  );

endinterface

// File: rtl/sysex_byte_out.sv
// sysex_byte_out
//   Registered holding stage for the outgoing SysEx byte with valid/ready
//   handshake, plus the 7-bit running checksum of the data bytes.
//   Ports: const_clk/iRST_N clock and async active-low reset;
//          load_i/byte_i present a new byte (may coincide with acceptance);
//          sum_clr_i/sum_add_i clear or accumulate byte_i[6:0];
//          tx_ready_i from transmitter; tx_data_o/tx_valid_o registered byte;
//          accept_o handshake completes this cycle; sum_o current checksum sum.
module sysex_byte_out
  import synth_sysex_pkg::*;
(
  input  logic       const_clk,
  input  logic       iRST_N,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  input  logic       sum_clr_i,
  input  logic       sum_add_i,
  input  logic       tx_ready_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  output logic       accept_o,
  output logic [6:0] sum_o
);

  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic [6:0] sum_q, sum_d;

  // Next-state for the holding register and checksum accumulator.
  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (load_i) begin
      // A load in the acceptance cycle lets the next byte present back-to-back.
      tx_data_d  = byte_i;
      tx_valid_d = 1'b1;
    end else if (tx_valid_q && tx_ready_i) begin
      tx_valid_d = 1'b0;
    end else begin
      tx_valid_d = tx_valid_q;
    end

    if (sum_clr_i) begin
      sum_d = 7'h00;
    end else if (sum_add_i) begin
      sum_d = sum_q + byte_i[6:0];
    end else begin
      sum_d = sum_q;
    end
  end

  // State registers.
  always_ff @(posedge const_clk or negedge iRST_N) begin
    if (!iRST_N) begin
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      sum_q      <= 7'h00;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      sum_q      <= sum_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign accept_o   = tx_valid_q & tx_ready_i;
  assign sum_o      = sum_q;

endmodule

// File: rtl/patch_dump_sequencer.sv
// patch_dump_sequencer
//   Walks every oscillator-section then common-section parameter address,
//   strobes a read on each, captures the returned byte and streams the patch
//   as F0 MFR DEV 10 <data...> <checksum> F7.
//   Ports: const_clk/iRST_N clock and async active-low reset;
//          dump_req start pulse (sampled in IDLE only); busy/done status;
//          bus (master modport) parameter bus and tx byte handshake.
module patch_dump_sequencer
  import synth_sysex_pkg::*;
#(
  parameter int         V_OSC      = 4,
  parameter int         OSC_STRIDE = OSC_STRIDE_DEF,
  parameter int         COM_LEN    = COM_LEN_DEF,
  parameter logic [7:0] MFR_ID     = 8'h7D,
  parameter logic [7:0] DEV_ID     = 8'h00
) (
  input  logic                   const_clk,
  input  logic                   iRST_N,
  input  logic                   dump_req,
  output logic                   busy,
  output logic                   done,
  patch_dump_sequencer_if.master bus
);

  localparam logic [6:0] OSC_LAST = 7'(V_OSC * OSC_STRIDE - 1);
  localparam logic [6:0] COM_LAST = 7'(COM_LEN - 1);

  sysex_state_e state_q;
  logic [1:0]   hdr_idx_q;
  logic         busy_q;
  logic         done_q;
  logic [6:0]   adr_q;
  logic         osc_sel_q;
  logic         com_sel_q;
  logic         read_q;
  logic         send_q;

  logic         load_s;
  logic [7:0]   load_byte_s;
  logic         sum_clr_s;
  logic         sum_add_s;
  logic         accept_s;
  logic [6:0]   sum_s;
  logic         osc_end_s;
  logic         last_s;

  function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return SOX;
      2'd1:    return MFR_ID;
      2'd2:    return DEV_ID;
      default: return CMD_DUMP;
    endcase
  endfunction

  // The active select doubles as the region flag while an address is in flight.
  assign osc_end_s = osc_sel_q && (adr_q == OSC_LAST);
  assign last_s    = com_sel_q && (adr_q == COM_LAST);

  // Byte-stage commands: which byte to present next and checksum bookkeeping.
  always_comb begin
    load_s      = 1'b0;
    load_byte_s = 8'h00;
    sum_clr_s   = 1'b0;
    sum_add_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dump_req) begin
          load_s      = 1'b1;
          load_byte_s = SOX;
          sum_clr_s   = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_HDR: begin
        if (accept_s && (hdr_idx_q != 2'd3)) begin
          load_s      = 1'b1;
          load_byte_s = hdr_byte(hdr_idx_q + 2'd1);
        end else begin
          load_s = 1'b0;
        end
      end
      ST_CAPTURE: begin
        load_s      = 1'b1;
        load_byte_s = bus.data & 8'h7F;
        sum_add_s   = 1'b1;
      end
      ST_SEND: begin
        // Checksum follows the last data byte without a gap cycle.
        if (accept_s && last_s) begin
          load_s      = 1'b1;
          load_byte_s = checksum_byte(sum_s);
        end else begin
          load_s = 1'b0;
        end
      end
      ST_SUM: begin
        if (accept_s) begin
          load_s      = 1'b1;
          load_byte_s = EOX;
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered bus and status outputs.
  always_ff @(posedge const_clk or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= ST_IDLE;
      hdr_idx_q <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      adr_q     <= 7'd0;
      osc_sel_q <= 1'b0;
      com_sel_q <= 1'b0;
      read_q    <= 1'b0;
      send_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (dump_req) begin
            busy_q    <= 1'b1;
            send_q    <= 1'b1;
            hdr_idx_q <= 2'd0;
            state_q   <= ST_HDR;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_HDR: begin
          if (accept_s) begin
            if (hdr_idx_q == 2'd3) begin
              adr_q     <= 7'd0;
              osc_sel_q <= 1'b1;
              com_sel_q <= 1'b0;
              state_q   <= ST_SETUP;
            end else begin
              hdr_idx_q <= hdr_idx_q + 2'd1;
            end
          end else begin
            state_q <= ST_HDR;
          end
        end
        ST_SETUP: begin
          read_q  <= 1'b1;
          state_q <= ST_STROBE;
        end
        ST_STROBE: begin
          read_q  <= 1'b0;
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          // Address and select only move once the captured byte has left.
          if (accept_s) begin
            if (last_s) begin
              adr_q     <= 7'd0;
              osc_sel_q <= 1'b0;
              com_sel_q <= 1'b0;
              state_q   <= ST_SUM;
            end else if (osc_end_s) begin
              adr_q     <= 7'd0;
              osc_sel_q <= 1'b0;
              com_sel_q <= 1'b1;
              state_q   <= ST_SETUP;
            end else begin
              adr_q   <= adr_q + 7'd1;
              state_q <= ST_SETUP;
            end
          end else begin
            state_q <= ST_SEND;
          end
        end
        ST_SUM: begin
          if (accept_s) begin
            state_q <= ST_EOX;
          end else begin
            state_q <= ST_SUM;
          end
        end
        ST_EOX: begin
          if (accept_s) begin
            busy_q  <= 1'b0;
            send_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_EOX;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  sysex_byte_out u_byte_out (
    .const_clk  (const_clk),
    .iRST_N     (iRST_N),
    .load_i     (load_s),
    .byte_i     (load_byte_s),
    .sum_clr_i  (sum_clr_s),
    .sum_add_i  (sum_add_s),
    .tx_ready_i (bus.tx_ready),
    .tx_data_o  (bus.tx_data),
    .tx_valid_o (bus.tx_valid),
    .accept_o   (accept_s),
    .sum_o      (sum_s)
  );

  assign busy                      = busy_q;
  assign done                      = done_q;
  assign bus.adr                   = adr_q;
  assign bus.osc_sel               = osc_sel_q;
  assign bus.com_sel               = com_sel_q;
  assign bus.read                  = read_q;
  assign bus.sysex_data_patch_send = send_q;

endmodule

// File: tb/tb_patch_dump_sequencer.sv
// Bench for patch_dump_sequencer: a pitch-register-file style slave model,
// a byte collector on the tx handshake, and a frame reference model built
// from plain arrays and modular arithmetic.
module tb_patch_dump_sequencer;

  logic const_clk;
  logic iRST_N;
  logic dump_req;
  logic busy;
  logic done;

  patch_dump_sequencer_if bus ();

  patch_dump_sequencer dut (
    .const_clk (const_clk),
    .iRST_N    (iRST_N),
    .dump_req  (dump_req),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  initial const_clk = 1'b0;
  always #5 const_clk = ~const_clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] osc_mem [64];
  logic [7:0] com_mem [16];
  logic [7:0] rx_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model: registers the addressed byte on the rising edge of read.
  always @(posedge bus.read) begin
    if (bus.osc_sel)      bus.data <= osc_mem[bus.adr[5:0]];
    else if (bus.com_sel) bus.data <= com_mem[bus.adr[3:0]];
    else                  bus.data <= 8'h00;
  end

  // Monitor history (previous two negedge samples).
  int         hist_n = 0;
  logic [6:0] p1_adr, p2_adr;
  logic       p1_osc, p2_osc, p1_com, p2_com, p1_read, p1_valid, p1_ready;
  logic [7:0] p1_data;

  // Collect accepted bytes and check bus/handshake invariants every cycle.
  always @(negedge const_clk) begin
    if (!iRST_N) begin
      hist_n = 0;
    end else begin
      if (bus.tx_valid && bus.tx_ready) rx_q.push_back(bus.tx_data);
      chk("sel_excl", 32'(bus.osc_sel & bus.com_sel), 32'd0);
      chk("read_while_pending", 32'(bus.read & bus.tx_valid), 32'd0);
      if (hist_n >= 1 && p1_valid && !p1_ready) begin
        chk("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
        chk("tx_hold_data", 32'(bus.tx_data), 32'(p1_data));
      end
      if (hist_n >= 2 && p1_read && !bus.read) begin
        chk("rd_adr_before", 32'(p2_adr), 32'(p1_adr));
        chk("rd_adr_after", 32'(bus.adr), 32'(p1_adr));
        chk("rd_sel_before", 32'({p2_osc, p2_com}), 32'({p1_osc, p1_com}));
        chk("rd_sel_after", 32'({bus.osc_sel, bus.com_sel}), 32'({p1_osc, p1_com}));
        chk("rd_one_sel", 32'(p1_osc ^ p1_com), 32'd1);
      end
      p2_adr = p1_adr; p2_osc = p1_osc; p2_com = p1_com;
      p1_adr = bus.adr; p1_osc = bus.osc_sel; p1_com = bus.com_sel;
      p1_read = bus.read; p1_valid = bus.tx_valid; p1_ready = bus.tx_ready;
      p1_data = bus.tx_data;
      if (hist_n < 2) hist_n++;
    end
  end

  // Pitch register file at reset: 0x40 at n*16+{0,1,8,9}, k_scale etc. 0; com adr0 = 3.
  task automatic set_defaults();
    for (int i = 0; i < 64; i++) osc_mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) com_mem[i] = 8'h00;
    for (int o = 0; o < 4; o++) begin
      osc_mem[o*16 + 0] = 8'h40;
      osc_mem[o*16 + 1] = 8'h40;
      osc_mem[o*16 + 8] = 8'h40;
      osc_mem[o*16 + 9] = 8'h40;
    end
    com_mem[0] = 8'h03;
  endtask

  // Reference frame: header, masked bytes in walk order, checksum, EOX.
  task automatic check_frame();
    logic [7:0] exp_q [$];
    logic [7:0] b;
    int sum;
    exp_q = {8'hF0, 8'h7D, 8'h00, 8'h10};
    sum = 0;
    for (int i = 0; i < 64; i++) begin b = osc_mem[i] & 8'h7F; exp_q.push_back(b); sum = sum + int'(b); end
    for (int i = 0; i < 16; i++) begin b = com_mem[i] & 8'h7F; exp_q.push_back(b); sum = sum + int'(b); end
    exp_q.push_back(8'((128 - (sum % 128)) % 128));
    exp_q.push_back(8'hF7);
    chk("frame_len", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("frame_byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
  endtask

  task automatic run_dump(input int stall_byte, input int stall_len, input int req_at,
                          input bit rnd_ready, output int cycles, output bit timed_out);
    int stalled;
    int cyc;
    stalled = 0;
    cyc = 0;
    rx_q.delete();
    @(posedge const_clk); #1; dump_req = 1'b1; bus.tx_ready = 1'b1;
    @(posedge const_clk); #1; dump_req = 1'b0;   // E0
    @(negedge const_clk);
    chk("first_valid", 32'(bus.tx_valid), 32'd1);
    chk("first_byte", 32'(bus.tx_data), 32'hF0);
    chk("busy_set", 32'(busy), 32'd1);
    while (!done && cyc < 5000) begin
      @(posedge const_clk); cyc++; #1;
      dump_req = (cyc == req_at);
      if (stall_byte >= 0 && rx_q.size() == 4 + stall_byte && bus.tx_valid && stalled < stall_len) begin
        bus.tx_ready = 1'b0;
        stalled++;
      end else if (rnd_ready) begin
        bus.tx_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.tx_ready = 1'b1;
      end
      @(negedge const_clk);
    end
    timed_out = !done;
    cycles = cyc;
    chk("busy_at_done", 32'(busy), 32'd0);
    @(posedge const_clk); #1; dump_req = 1'b0; bus.tx_ready = 1'b1;
    @(negedge const_clk);
    chk("done_pulse_end", 32'(done), 32'd0);
  endtask

  typedef struct {
    logic [7:0] osc2_val;
    int         stall_byte;
    int         stall_len;
    int         req_at;
    int         exp_cycles;
    logic [7:0] exp_csum;
  } scen_t;

  initial begin
    scen_t tbl [4];
    int    cycles;
    bit    timed_out;
    int    cyc;

    tbl[0] = '{8'h40, -1, 0, -1, 326, 8'h7D};  // defaults
    tbl[1] = '{8'hC5, -1, 0, -1, 326, 8'h78};  // osc_ct[2]=0xC5 -> 0x45
    tbl[2] = '{8'h40, 10, 5, -1, 331, 8'h7D};  // 5-cycle stall on data byte 10
    tbl[3] = '{8'h40, -1, 0, 50, 326, 8'h7D};  // dump_req while busy

    dump_req = 1'b0;
    bus.tx_ready = 1'b1;
    iRST_N = 1'b1;
    #2 iRST_N = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_adr", 32'(bus.adr), 32'd0);
    chk("rst_osc_sel", 32'(bus.osc_sel), 32'd0);
    chk("rst_com_sel", 32'(bus.com_sel), 32'd0);
    chk("rst_read", 32'(bus.read), 32'd0);
    chk("rst_send", 32'(bus.sysex_data_patch_send), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    repeat (3) @(posedge const_clk);
    #1 iRST_N = 1'b1;
    repeat (3) @(posedge const_clk);
    @(negedge const_clk);
    chk("idle_tx_valid", 32'(bus.tx_valid), 32'd0);

    for (int s = 0; s < 4; s++) begin
      set_defaults();
      osc_mem[32] = tbl[s].osc2_val;
      run_dump(tbl[s].stall_byte, tbl[s].stall_len, tbl[s].req_at, 1'b0, cycles, timed_out);
      chk("timeout", 32'(timed_out), 32'd0);
      chk("done_cycle", 32'(cycles), 32'(tbl[s].exp_cycles));
      check_frame();
      if (rx_q.size() > 84) chk("csum", 32'(rx_q[84]), 32'(tbl[s].exp_csum));
      if (rx_q.size() > 36) chk("adr20_byte", 32'(rx_q[36]), 32'(tbl[s].osc2_val & 8'h7F));
      repeat (20) @(posedge const_clk);
      @(negedge const_clk);
      chk("no_extra_frame", 32'(rx_q.size()), 32'd86);
      chk("idle_after", 32'(busy), 32'd0);
    end

    // Random patch contents with random backpressure.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 64; i++) osc_mem[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 16; i++) com_mem[i] = 8'($urandom_range(0, 255));
      run_dump(-1, 0, -1, 1'b1, cycles, timed_out);
      chk("rnd_timeout", 32'(timed_out), 32'd0);
      check_frame();
    end

    // Async reset in the middle of the data phase, then a clean dump.
    set_defaults();
    rx_q.delete();
    @(posedge const_clk); #1; dump_req = 1'b1; bus.tx_ready = 1'b1;
    @(posedge const_clk); #1; dump_req = 1'b0;
    cyc = 0;
    while (rx_q.size() < 44 && cyc < 2000) begin
      @(posedge const_clk); #1; cyc++;
    end
    chk("mid_reach", 32'(rx_q.size() >= 44), 32'd1);
    iRST_N = 1'b0;
    #1;
    chk("mid_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_osc_sel", 32'(bus.osc_sel), 32'd0);
    chk("mid_rst_com_sel", 32'(bus.com_sel), 32'd0);
    chk("mid_rst_send", 32'(bus.sysex_data_patch_send), 32'd0);
    chk("mid_rst_read", 32'(bus.read), 32'd0);
    chk("mid_rst_adr", 32'(bus.adr), 32'd0);
    repeat (3) @(posedge const_clk);
    #1 iRST_N = 1'b1;
    run_dump(-1, 0, -1, 1'b0, cycles, timed_out);
    chk("post_rst_timeout", 32'(timed_out), 32'd0);
    chk("post_rst_cycle", 32'(cycles), 32'd326);
    check_frame();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
